// File: rtl/itrx_apbm_spi_pclk_gen.sv
// Divided peripheral clock-enable generator running on the SPI serial clock.
// Optional per-frame pclk_en counter: define ITRX_APBM_SPI_PCLK_EDGE_CNT_EN.
module itrx_apbm_spi_pclk_gen #(
    parameter int CPOL_MODE = 0,
    parameter int CPHA_MODE = 1,
    parameter int DIV_W     = 3
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             start,
    input  logic             pwrite,
    input  logic [DIV_W-1:0] div_m1,
    input  logic [DIV_W-1:0] wr_pha,
    input  logic [DIV_W-1:0] rd_pha,
    output logic             pclk_en,
    output logic             pclk_re_e,
    output logic             pclk_div,
    output logic             busy,
    output logic [7:0]       edge_cnt,
    output logic [1:0]       state_dbg
);

    // Frame protocol: start is a single-cycle pulse sampled only in IDLE with
    // cs_n low; cs_n high ends the frame on the next edge from any state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam bit SCLK_INV = (CPOL_MODE == CPHA_MODE);

    logic             sclk_loc;
    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pha_sel;
    logic [DIV_W-1:0] pha_clamp;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W:0]   half;
    logic             active;
    logic             hit;
    logic             div_hi;

    assign sclk_loc  = SCLK_INV ? ~sclk : sclk;
    assign state_dbg = state;

    always_comb begin
        pha_sel   = pwrite ? wr_pha : rd_pha;
        pha_clamp = (pha_sel > div_m1) ? div_m1 : pha_sel;
        active    = (state != ST_IDLE);
        hit       = (cnt == div_q);
        cnt_nxt   = hit ? '0 : cnt + DIV_W'(1);
        // ceil((div_q+1)/2), one bit wider so div_q = all-ones does not wrap
        half      = ({1'b0, div_q} + (DIV_W+1)'(2)) >> 1;
        div_hi    = (div_q != '0) && ({1'b0, cnt_nxt} < half);
        pclk_re_e = active && hit && !cs_n;
    end

    always_ff @(posedge sclk_loc or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            div_q    <= '0;
            pclk_en  <= 1'b0;
            pclk_div <= 1'b0;
            busy     <= 1'b0;
        end else if (cs_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            pclk_en  <= 1'b0;
            pclk_div <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pclk_en  <= 1'b0;
                    pclk_div <= 1'b0;
                    if (start) begin
                        state <= ST_ALIGN;
                        div_q <= div_m1;
                        cnt   <= pha_clamp;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                ST_ALIGN, ST_RUN: begin
                    cnt      <= cnt_nxt;
                    pclk_en  <= hit;
                    busy     <= 1'b1;
                    // The divided clock only starts once RUN is entered, aligned to pclk_en
                    pclk_div <= ((state == ST_RUN) || hit) && div_hi;
                    if (hit) state <= ST_RUN;
                end
                default: begin
                    state    <= ST_IDLE;
                    pclk_en  <= 1'b0;
                    pclk_div <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef ITRX_APBM_SPI_PCLK_EDGE_CNT_EN
    logic frame_start;
    assign frame_start = (state == ST_IDLE) && !cs_n && start;

    // Counts in step with pclk_en, so the value includes the pulse now visible
    always_ff @(posedge sclk_loc or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 8'd0;
        end else if (frame_start) begin
            edge_cnt <= 8'd0;
        end else if (pclk_re_e && (edge_cnt != 8'd255)) begin
            edge_cnt <= edge_cnt + 8'd1;
        end
    end
`else
    assign edge_cnt = 8'd0;
`endif

endmodule

// File: doc/itrx_apbm_spi_pclk_gen.md
ITRX_APBM_SPI_PCLK_GEN -- requirements
Module: itrx_apbm_spi_pclk_gen

Interface
REQ-001 SHALL have parameter CPOL_MODE, default 0, SPI clock polarity.
REQ-002 SHALL have parameter CPHA_MODE, default 1, SPI clock phase; internal clock sclk_loc = sclk when CPOL_MODE != CPHA_MODE, else ~sclk.
REQ-003 SHALL have parameter DIV_W, default 3, width of divide/phase fields (divide range 1..2**DIV_W).
REQ-004 SHALL have ports: sclk  in  1  SPI serial clock, sole clock; all flops on rising sclk_loc.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cs_n  in  1  frame select, active-low, synchronous to sclk_loc.
REQ-007 start  in  1  one-cycle pulse: R/W bit received, frame clocking begins.
REQ-008 pwrite  in  1  selects wr_pha (1) or rd_pha (0) at start.
REQ-009 div_m1  in  DIV_W  divide ratio minus one.
REQ-010 wr_pha, rd_pha  in  DIV_W each  initial counter phase for write/read frames.
REQ-011 pclk_en  out  1  one-sclk-cycle clock-enable per pclk period (for downstream ICG).
REQ-012 pclk_re_e  out  1  early rising-edge indication, asserted the cycle before pclk_en.
REQ-013 pclk_div  out  1  registered divided clock, ~50% duty, for divide >= 2.
REQ-014 busy  out  1  high in ALIGN or RUN.
REQ-015 edge_cnt  out  8  pclk_en pulses this frame (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> ALIGN -> RUN; cs_n high in any state -> IDLE next cycle (highest priority).
REQ-017 In IDLE with cs_n low and start high: SHALL latch div_m1 into div_q, load cnt with min(pwrite ? wr_pha : rd_pha, div_m1), go to ALIGN.
REQ-018 div_m1/wr_pha/rd_pha changes outside IDLE SHALL be ignored until next frame.
REQ-019 start while in ALIGN/RUN SHALL be ignored.
REQ-020 cnt SHALL increment each cycle in ALIGN/RUN, wrapping from div_q to 0 (no overflow for div_q = 2**DIV_W-1).
REQ-021 pclk_en SHALL be registered, high for exactly the cycle after cnt == div_q in ALIGN/RUN; first pclk_en moves ALIGN -> RUN.
REQ-022 pclk_re_e SHALL be combinational: (cnt == div_q) and state in {ALIGN, RUN} and cs_n low.
REQ-023 div_q = 0 (divide-by-1): pclk_re_e and pclk_en SHALL be high every cycle after the first in ALIGN/RUN.
REQ-024 pclk_div SHALL be 0 in IDLE/ALIGN and when div_q = 0; in RUN high for cycles with cnt < ceil((div_q+1)/2), low otherwise, registered.
REQ-025 Leaving RUN (cs_n high) SHALL force pclk_en, pclk_div low in the same cycle busy drops; no runt high pulse shorter than one sclk cycle.
REQ-026 busy SHALL be registered, = (state != IDLE).

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, cnt 0, div_q 0, pclk_en 0, pclk_div 0, busy 0, edge_cnt 0; pclk_re_e thereby 0.
REQ-028 Reset mid-frame SHALL abort the frame; release requires a new start with cs_n low.

Configuration
REQ-029 Macro ITRX_APBM_SPI_PCLK_EDGE_CNT_EN defined: edge_cnt SHALL clear on entry to ALIGN, increment per pclk_en, saturate at 255, hold in IDLE until next start.
REQ-030 Macro undefined: edge_cnt SHALL be tied 0 and no counter flops synthesised; all other behaviour identical.

Verification
REQ-031 div_m1=3, wr_pha=0, pwrite=1, start -> pclk_re_e at cnt 3, first pclk_en 4 cycles after start, period 4, pclk_div 2 high/2 low.
REQ-032 div_m1=4, rd_pha=2, pwrite=0 -> first pclk_en 3 cycles after start, then period 5, pclk_div 3 high/2 low.
REQ-033 div_m1=0 -> pclk_en high every cycle in RUN, pclk_div stays 0; rd_pha=5 clamps to 0.
REQ-034 cs_n high while pclk_div high in RUN with div_m1=7 -> next cycle pclk_div=0, pclk_en=0, busy=0, state IDLE; div_m1 changed mid-frame to 1 has no effect.
REQ-035 rst_n low mid-RUN -> all outputs 0 immediately; start pulse during RUN ignored (period unchanged).
REQ-036 With ITRX_APBM_SPI_PCLK_EDGE_CNT_EN, div_m1=0 for 300 cycles -> edge_cnt saturates at 255; without macro edge_cnt stays 0.
